// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note tone player: player FSM state encoding,
// default parameter values and the half-period helper.
// No ports (package).
// -----------------------------------------------------------------------------
package note_pkg;

  // Player FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Default parameter values
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_NOTE_CYCLES = 12500000;
  localparam int DEF_GAP_CYCLES  = 1250000;
  localparam int DEF_HALF_SCALE  = 1000;

  // Width of the half-period product (8-bit code x 16-bit scale)
  localparam int HALF_W = 24;

  // Half-period in clocks: an 8x16 product always fits in 24 bits.
  function automatic logic [HALF_W-1:0] half_period(input logic [7:0] code,
                                                    input logic [15:0] scale);
    return HALF_W'(code) * HALF_W'(scale);
  endfunction

endpackage

// File: rtl/note_fifo.sv
// -----------------------------------------------------------------------------
// note_fifo
// Synchronous first-word-fall-through FIFO for 8-bit note codes.
// The head entry is visible on rd_data whenever the FIFO is not empty, so the
// consumer can load it on the same edge it pops.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   push, wr_data   - write strobe (caller guarantees not full, or popping)
//   pop, rd_data    - read strobe (caller guarantees not empty), head data
//   full, empty     - occupancy flags
//   count           - number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module note_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Storage array write port (contents need no reset: count gates validity)
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Next pointer and occupancy; pointers wrap naturally as DEPTH is 2^AW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/note_tone_player.sv
// -----------------------------------------------------------------------------
// note_tone_player
// Queues incoming note codes and plays each one as a square wave for
// NOTE_CYCLES clocks, followed by GAP_CYCLES clocks of silence. The square
// wave half-period is note_code*HALF_SCALE clocks; code 0 is a silent rest.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   in_valid    - note strobe; in_data is the note code to queue
//   tone_out    - square-wave audio output
//   playing     - high while a note is sounding
//   note_code   - code most recently taken from the queue
//   overflow    - sticky: a note arrived while the queue was full
//   fifo_count  - current queue occupancy
// -----------------------------------------------------------------------------
module note_tone_player
  import note_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int NOTE_CYCLES = DEF_NOTE_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int HALF_SCALE  = DEF_HALF_SCALE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          tone_out,
  output logic                          playing,
  output logic [7:0]                    note_code,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DUR_W = $clog2(NOTE_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [DUR_W-1:0]  DUR_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [15:0]       SCALE    = 16'(HALF_SCALE);

  state_e             state_q, state_d;
  logic [7:0]         note_code_q, note_code_d;
  logic               tone_q, tone_d;
  logic               playing_q, playing_d;
  logic               overflow_q, overflow_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [HALF_W-1:0]  half_q, half_d;

  logic               push_s, pop_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [7:0]         fifo_head_s;
  logic [HALF_W-1:0]  half_period_s;

  note_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (in_data),
    .pop     (pop_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  assign half_period_s = half_period(note_code_q, SCALE);

  // Queue handshake: a pop frees a slot on the same edge, so a full queue
  // still accepts a push while popping.
  always_comb begin
    pop_s  = (state_q == IDLE) && !fifo_empty_s;
    push_s = in_valid && (!fifo_full_s || pop_s);
  end

  // Player FSM next state, counters and output values
  always_comb begin
    state_d     = state_q;
    note_code_d = note_code_q;
    tone_d      = tone_q;
    playing_d   = playing_q;
    dur_d       = dur_q;
    gap_d       = gap_q;
    half_d      = half_q;

    if (in_valid && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    case (state_q)
      IDLE: begin
        tone_d    = 1'b0;
        playing_d = 1'b0;
        if (pop_s) begin
          state_d     = PLAY;
          note_code_d = fifo_head_s;
          playing_d   = 1'b1;
          dur_d       = '0;
          half_d      = '0;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (dur_q == DUR_LAST) begin
          state_d   = GAP;
          playing_d = 1'b0;
          tone_d    = 1'b0;
          gap_d     = '0;
        end else begin
          dur_d = dur_q + DUR_ONE;
          // A zero half-period is a rest: keep the output low.
          if (half_period_s == '0) begin
            tone_d = 1'b0;
            half_d = '0;
          end else if (half_q == half_period_s - 24'd1) begin
            tone_d = ~tone_q;
            half_d = '0;
          end else begin
            half_d = half_q + 24'd1;
          end
        end
      end
      GAP: begin
        tone_d    = 1'b0;
        playing_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        tone_d    = 1'b0;
        playing_d = 1'b0;
      end
    endcase
  end

  // Player state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      note_code_q <= 8'd0;
      tone_q      <= 1'b0;
      playing_q   <= 1'b0;
      overflow_q  <= 1'b0;
      dur_q       <= '0;
      gap_q       <= '0;
      half_q      <= '0;
    end else begin
      state_q     <= state_d;
      note_code_q <= note_code_d;
      tone_q      <= tone_d;
      playing_q   <= playing_d;
      overflow_q  <= overflow_d;
      dur_q       <= dur_d;
      gap_q       <= gap_d;
      half_q      <= half_d;
    end
  end

  assign tone_out  = tone_q;
  assign playing   = playing_q;
  assign note_code = note_code_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_note_tone_player.sv
// -----------------------------------------------------------------------------
// tb_note_tone_player
// Self-checking bench for note_tone_player. A reference model tracks the
// note queue and, for each note, the edge at which it started sounding; the
// expected tone is derived from elapsed time divided by the half-period.
// -----------------------------------------------------------------------------
module tb_note_tone_player;

  localparam int DEPTH  = 8;
  localparam int NOTE_C = 100;
  localparam int GAP_C  = 10;
  localparam int SCALE  = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       tone_out;
  logic       playing;
  logic [7:0] note_code;
  logic       overflow;
  logic [3:0] fifo_count;

  note_tone_player #(
    .FIFO_DEPTH  (DEPTH),
    .NOTE_CYCLES (NOTE_C),
    .GAP_CYCLES  (GAP_C),
    .HALF_SCALE  (SCALE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .tone_out   (tone_out),
    .playing    (playing),
    .note_code  (note_code),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 = silent/waiting, 1 = sounding, 2 = after-note gap
  int m_mode;
  int m_q[$];
  int m_code;
  int m_start;
  int m_gstart;
  bit m_over;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_q      = {};
    m_code   = 0;
    m_start  = 0;
    m_gstart = 0;
    m_over   = 1'b0;
  endtask

  // One clock edge of the specified behaviour
  task automatic model_step();
    bit take;
    bit was_full;
    int head;
    head     = 0;
    was_full = (m_q.size() == DEPTH);
    take     = (m_mode == 0) && (m_q.size() > 0);
    if (take) head = m_q.pop_front();
    if (in_valid) begin
      if (!was_full || take) m_q.push_back(int'(in_data));
      else m_over = 1'b1;
    end
    if (m_mode == 0) begin
      if (take) begin
        m_code  = head;
        m_mode  = 1;
        m_start = cyc;
      end
    end else if (m_mode == 1) begin
      if (cyc - m_start == NOTE_C) begin
        m_mode   = 2;
        m_gstart = cyc;
      end
    end else begin
      if (cyc - m_gstart == GAP_C) m_mode = 0;
    end
  endtask

  task automatic compare_all();
    int hp;
    int exp_tone;
    hp = m_code * SCALE;
    exp_tone = (m_mode == 1 && hp != 0) ? (((cyc - m_start) / hp) % 2) : 0;
    check_eq("playing",    32'(playing),    32'(m_mode == 1));
    check_eq("tone_out",   32'(tone_out),   32'(exp_tone));
    check_eq("note_code",  32'(note_code),  32'(m_code));
    check_eq("overflow",   32'(overflow),   32'(m_over));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic push_note(input int code);
    in_valid = 1'b1;
    in_data  = 8'(code);
    tick();
    in_valid = 1'b0;
  endtask

  // Asynchronous reset pulse asserted between edges
  task automatic reset_pulse(input int edges);
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("async_rst_playing", 32'(playing),    32'd0);
    check_eq("async_rst_tone",    32'(tone_out),   32'd0);
    check_eq("async_rst_code",    32'(note_code),  32'd0);
    check_eq("async_rst_ovf",     32'(overflow),   32'd0);
    check_eq("async_rst_count",   32'(fifo_count), 32'd0);
    for (int i = 0; i < edges; i++) tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (m_mode == 0 && m_q.size() == 0) break;
      tick();
    end
    tick();
    check_eq("drain_playing", 32'(playing),    32'd0);
    check_eq("drain_count",   32'(fifo_count), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    model_reset();
    tick();
    tick();
    check_eq("rst_playing", 32'(playing),    32'd0);
    check_eq("rst_count",   32'(fifo_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single note: 2-edge latency, toggle every 40 clocks
    push_note(40);
    check_eq("lat_after_push", 32'(playing), 32'd0);
    tick();
    check_eq("lat_after_pop", 32'(playing), 32'd1);
    check_eq("first_code",    32'(note_code), 32'd40);
    for (int i = 0; i < 39; i++) tick();
    check_eq("tone_before_40", 32'(tone_out), 32'd0);
    tick();
    check_eq("tone_at_40", 32'(tone_out), 32'd1);
    drain();

    // Five notes back to back, played in order
    for (int k = 0; k < 5; k++) push_note(40 + 4 * k);
    drain();
    check_eq("seq_last_code", 32'(note_code), 32'd56);
    check_eq("seq_overflow",  32'(overflow),  32'd0);

    // Ten notes: one popped, eight queued, one dropped
    for (int k = 0; k < 10; k++) push_note(41 + k);
    check_eq("burst_count",    32'(fifo_count), 32'd8);
    check_eq("burst_overflow", 32'(overflow),   32'd1);
    for (int i = 0; i < 30; i++) tick();
    reset_pulse(2);
    tick();

    // Rest note
    push_note(0);
    drain();

    // Reset 50 clocks into a note with three queued, then silence
    for (int k = 0; k < 4; k++) push_note(44 + k);
    for (int i = 0; i < 47; i++) tick();
    check_eq("pre_rst_count", 32'(fifo_count), 32'd3);
    reset_pulse(1);
    for (int i = 0; i < 200; i++) tick();

    // Full queue in IDLE with a simultaneous push
    for (int k = 0; k < 9; k++) push_note(40 + k);
    for (int i = 0; i < 300; i++) begin
      if (m_mode == 0) break;
      tick();
    end
    check_eq("full_wait_count", 32'(fifo_count), 32'd8);
    push_note(50);
    check_eq("full_push_count", 32'(fifo_count), 32'd8);
    check_eq("full_push_ovf",   32'(overflow),   32'd0);
    check_eq("full_push_play",  32'(playing),    32'd1);
    reset_pulse(1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 24) == 0);
      in_data  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(40, 56));
      if ($urandom_range(0, 999) == 0) begin
        in_valid = 1'b0;
        reset_pulse(1);
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
